// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Issue/response bundle between the EX pipeline and md_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, a, b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative RV32M multiply/divide unit (radix-2 shift-add and
//                restoring shift-subtract on operand magnitudes).
//                Optional macro MD_FAST_MUL_EN: single-cycle multiply path.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    md_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    // Operand decode for the request presented in IDLE
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic              w_accept;
    logic              w_fast;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_is_div   = bus.op[2];
    assign w_a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_a_neg    = w_a_signed & bus.a[XLEN-1];
    assign w_b_neg    = w_b_signed & bus.b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag    = w_b_neg ? -bus.b : bus.b;
    assign w_div_zero = w_is_div & (bus.b == '0);
    assign w_ovf      = w_is_div & ~bus.op[0] & (bus.a == c_int_min) & (bus.b == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_accept   = (r_state == S_IDLE) & bus.start & ~bus.kill;

`ifdef MD_FAST_MUL_EN
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    // Sign-extended operands give the exact signed product modulo 2^64
    assign w_a_ext     = {{XLEN{w_a_neg}}, bus.a};
    assign w_b_ext     = {{XLEN{w_b_neg}}, bus.b};
    assign w_fast_prod = w_a_ext * w_b_ext;
    assign w_fast      = ~w_is_div;
`else
    assign w_fast_prod = '0;
    assign w_fast      = 1'b0;
`endif

    // One radix-2 step of each algorithm
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_diff[XLEN];

    // Sign correction and output selection
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -r_lo : r_lo;
    assign w_rem    = r_neg ? -r_hi : r_hi;

    always_comb begin
        w_final = w_rem;
        case (r_op)
            3'd0:                w_final = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_final = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_final = w_quo;
            default:             w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_special || w_fast) ? S_FINISH : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    w_next = S_IDLE;
                end else if (r_cnt == c_last) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_cnt <= '0;
                        r_b   <= w_b_mag;
                        if (w_special) begin
                            // Preload quotient/remainder slots with the architectural answer
                            r_neg <= 1'b0;
                            r_lo  <= w_div_zero ? '1 : c_int_min;
                            r_hi  <= w_div_zero ? bus.a : '0;
                        end else if (w_fast) begin
                            r_neg <= 1'b0;
                            r_hi  <= w_fast_prod[2*XLEN-1:XLEN];
                            r_lo  <= w_fast_prod[XLEN-1:0];
                        end else begin
                            r_neg <= (w_is_div & bus.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                            r_hi  <= '0;
                            r_lo  <= w_a_mag;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                S_FINISH: begin
                    if (!bus.kill) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Directed self-checking bench for md_unit against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md_unit_if #(.XLEN(32)) bus();

    md_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Requests posted by the stimulus, consumed by the checker
    int         iss_seq = 0;
    int         iss_cyc = 0;
    logic [2:0] iss_op  = '0;
    logic [31:0] iss_a  = '0;
    logic [31:0] iss_b  = '0;
    logic [31:0] iss_lit = '0;
    int         abt_seq = 0;
    bit         abt_rst = 1'b0;
    int         to_cnt  = 0;
    bit         chk_en  = 1'b0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4:       p = (b == 32'h0) ? -64'sd1 : sa / sb;
            3'd5:       p = (b == 32'h0) ? -64'sd1 : ua / ub;
            3'd6:       p = (b == 32'h0) ? sa : sa % sb;
            default:    p = (b == 32'h0) ? ua : ua % ub;
        endcase
        return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'h0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 2;
`ifdef MD_FAST_MUL_EN
        if (!op[2])
            return 2;
`endif
        return 34;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Checker: model state lives here only
    int          seen_iss = 0, seen_abt = 0, seen_to = 0;
    bit          pending  = 1'b0;
    int          issue_c  = 0, exp_edge = 0;
    logic [31:0] exp_res = '0, last_res = '0, lit_res = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (abt_seq != seen_abt) begin
                seen_abt = abt_seq;
                pending  = 1'b0;
                if (abt_rst) last_res = '0;
            end
            if (iss_seq != seen_iss) begin
                seen_iss = iss_seq;
                pending  = 1'b1;
                issue_c  = iss_cyc;
                exp_res  = model(iss_op, iss_a, iss_b);
                exp_edge = iss_cyc + lat(iss_op, iss_a, iss_b);
                lit_res  = iss_lit;
            end
            if (to_cnt != seen_to) begin
                seen_to = to_cnt;
                total++;
                bad++;
                $display("FAIL timeout: done not seen, got none want pulse (cycle %0d)", cyc);
            end
            chk("busy", 32'(bus.busy), 32'(pending && cyc > issue_c && cyc < exp_edge));
            chk("done", 32'(bus.done), 32'(pending && cyc == exp_edge));
            if (pending && cyc == exp_edge) begin
                last_res = exp_res;
                pending  = 1'b0;
                chk("literal", bus.result, lit_res);
            end
            chk("result", bus.result, last_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        iss_op    = op;
        iss_a     = a;
        iss_b     = b;
        iss_lit   = lit;
        iss_cyc   = cyc;
        iss_seq++;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) to_cnt++;
        tick();
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        issue(op, a, b, lit);
        wait_done();
    endtask

    task automatic abort_now(input bit by_rst);
        abt_rst = by_rst;
        abt_seq++;
    endtask

    initial begin
        bus.start = 1'b1;
        bus.kill  = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        tick();
        abort_now(1'b1);
        chk_en = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();

        run(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
        run(3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF);
        run(3'd3, 32'hFFFFFFFD, 32'd7, 32'h00000006);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run(3'd5, 32'd100, 32'd0, 32'hFFFFFFFF);
        run(3'd7, 32'd100, 32'd0, 32'd100);
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        // Second start while busy must be dropped
        issue(3'd5, 32'd1000, 32'd3, 32'd333);
        repeat (8) tick();
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        tick();
        bus.start = 1'b0;
        wait_done();
        run(3'd0, 32'd6, 32'd7, 32'd42);

        // kill sampled on edge 20 of a divide
        issue(3'd4, 32'd12345, 32'd7, 32'd0);
        repeat (18) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        abort_now(1'b0);
        repeat (3) tick();

        // kill while in FINISH suppresses done
        issue(3'd7, 32'd50, 32'd7, 32'd0);
        repeat (32) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        abort_now(1'b0);
        repeat (3) tick();

        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run(3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001);
        run(3'd6, 32'd7, 32'hFFFFFFFE, 32'd1);
        run(3'd0, 32'd0, 32'd5, 32'd0);

        // Reset on edge 15 of a divide
        issue(3'd4, 32'd999, 32'd10, 32'd0);
        repeat (13) tick();
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        abort_now(1'b1);
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();

        run(3'd0, 32'd6, 32'd7, 32'd42);
        run(3'd4, 32'd99, 32'd9, 32'd11);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
